// File: rtl/zlib_frame_ctrl_pkg.sv
// Shared constants and FSM encoding for the PNG zlib frame sequencer.
package zlib_frame_ctrl_pkg;

    localparam int unsigned ADLER_MOD     = 65521;
    localparam int unsigned PIX_BYTES_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_FILT  = 3'd2,
        ST_PIX   = 3'd3,
        ST_CHK   = 3'd4,
        ST_WAIT  = 3'd5
    } state_t;

endpackage

// File: rtl/zlib_frame_ctrl_adler32_acc.sv
// Adler-32 accumulator: folds one byte per enabled cycle, clear restarts at s1=1,s2=0.
// Result visible the cycle after the byte is presented; no backpressure.
module adler32_acc
    import zlib_frame_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [7:0]  dat_i,
    output logic [31:0] sum_o
);

    logic [15:0] s1_q, s2_q;
    logic [16:0] s1_sum, s2_sum;
    logic [15:0] s1_n, s2_n;

    // Both partial sums stay below 2*ADLER_MOD, so one subtract brings them in range.
    always_comb begin
        s1_sum = {1'b0, s1_q} + {9'd0, dat_i};
        s1_n   = (s1_sum >= 17'(ADLER_MOD)) ? 16'(s1_sum - 17'(ADLER_MOD)) : s1_sum[15:0];
        s2_sum = {1'b0, s2_q} + {1'b0, s1_n};
        s2_n   = (s2_sum >= 17'(ADLER_MOD)) ? 16'(s2_sum - 17'(ADLER_MOD)) : s2_sum[15:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 16'd1;
            s2_q <= 16'd0;
        end else if (clr_i) begin
            s1_q <= 16'd1;
            s2_q <= 16'd0;
        end else if (en_i) begin
            s1_q <= s1_n;
            s2_q <= s2_n;
        end
    end

    assign sum_o = {s2_q, s1_q};

endmodule

// File: rtl/zlib_frame_ctrl.sv
// Sequences one PNG image: emits filter+pixel bytes to LZ77, computes Adler-32, holds it until encoder done.
// First byte valid 2 cycles after start; 1 byte/cycle, stalls on byte_rdy_i and pix_val_i.
module zlib_frame_ctrl
    import zlib_frame_ctrl_pkg::*;
#(
    parameter int W_WD   = 16,
    parameter int H_WD   = 16,
    parameter int PIX_WD = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [W_WD-1:0]   width_i,
    input  logic [H_WD-1:0]   height_i,
    input  logic [2:0]        bpp_i,
    input  logic              pix_val_i,
    input  logic [PIX_WD-1:0] pix_dat_i,
    output logic              pix_rdy_o,
    output logic              byte_val_o,
    output logic [7:0]        byte_dat_o,
    output logic              byte_lst_o,
    input  logic              byte_rdy_i,
    output logic              enc_start_o,
    input  logic              enc_done_i,
    output logic              adler_val_o,
    output logic [31:0]       adler_o,
    output logic              busy_o,
    output logic              err_o
);

    state_t state_q, state_d;

    logic [W_WD-1:0]   width_q, col_q;
    logic [H_WD-1:0]   height_q, row_q;
    logic [2:0]        bpp_q;
    logic [1:0]        bidx_q;
    logic [PIX_WD-1:0] pix_buf_q;
    logic              buf_full_q;
    logic [31:0]       adler_q;
    logic              adler_val_q;
    logic              err_q;

    logic        cfg_ok, xfer, last_byte, last_col, last_row, pix_done, pix_load;
    logic [1:0]  sel;
    logic [31:0] sum;

    assign cfg_ok = (width_i != '0) && (height_i != '0) && (bpp_i != 3'd0)
                    && (bpp_i <= 3'(PIX_BYTES_MAX));

    assign last_byte = ({1'b0, bidx_q} == (bpp_q - 3'd1));
    assign last_col  = (col_q == (width_q - W_WD'(1)));
    assign last_row  = (row_q == (height_q - H_WD'(1)));

    assign byte_val_o = (state_q == ST_FILT) || ((state_q == ST_PIX) && buf_full_q);
    assign xfer       = byte_val_o && byte_rdy_i;
    assign pix_done   = (state_q == ST_PIX) && xfer && last_byte;

    // Reload during the final byte keeps 1 byte/cycle inside a row; a row's end always goes via FILT.
    assign pix_rdy_o  = (state_q == ST_PIX) && (!buf_full_q || (pix_done && !last_col));
    assign pix_load   = pix_val_i && pix_rdy_o;

    // Byte k of a pixel sits at [8*(bpp-k)-1 -: 8]; mod-4 arithmetic covers bpp=4.
    assign sel        = bpp_q[1:0] - 2'd1 - bidx_q;
    assign byte_dat_o = (state_q == ST_PIX) ? pix_buf_q[{sel, 3'b000} +: 8] : 8'h00;
    assign byte_lst_o = (state_q == ST_PIX) && buf_full_q && last_byte && last_col && last_row;

    assign enc_start_o = (state_q == ST_START);
    assign busy_o      = (state_q != ST_IDLE);
    assign adler_val_o = adler_val_q;
    assign adler_o     = adler_q;
    assign err_o       = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i && cfg_ok) state_d = ST_START;
            ST_START: state_d = ST_FILT;
            ST_FILT:  if (xfer) state_d = ST_PIX;
            ST_PIX:   if (pix_done && last_col) state_d = last_row ? ST_CHK : ST_FILT;
            ST_CHK:   state_d = ST_WAIT;
            ST_WAIT:  if (enc_done_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            width_q     <= '0;
            height_q    <= '0;
            bpp_q       <= '0;
            err_q       <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            bidx_q      <= '0;
            pix_buf_q   <= '0;
            buf_full_q  <= 1'b0;
            adler_q     <= '0;
            adler_val_q <= 1'b0;
        end else begin
            err_q <= (state_q == ST_IDLE) && start_i && !cfg_ok;

            if ((state_q == ST_IDLE) && start_i && cfg_ok) begin
                width_q  <= width_i;
                height_q <= height_i;
                bpp_q    <= bpp_i;
            end

            if (state_q == ST_START) begin
                row_q      <= '0;
                col_q      <= '0;
                bidx_q     <= '0;
                buf_full_q <= 1'b0;
            end else if ((state_q == ST_PIX) && xfer) begin
                if (last_byte) begin
                    bidx_q <= '0;
                    if (last_col) begin
                        col_q <= '0;
                        row_q <= row_q + H_WD'(1);
                    end else begin
                        col_q <= col_q + W_WD'(1);
                    end
                end else begin
                    bidx_q <= bidx_q + 2'd1;
                end
            end

            if (pix_load) begin
                pix_buf_q  <= pix_dat_i;
                buf_full_q <= 1'b1;
            end else if (pix_done) begin
                buf_full_q <= 1'b0;
            end

            if (state_q == ST_CHK) begin
                adler_q     <= sum;
                adler_val_q <= 1'b1;
            end else if ((state_q == ST_WAIT) && enc_done_i) begin
                adler_val_q <= 1'b0;
            end
        end
    end

    adler32_acc u_adler (
        .clk   (clk),
        .rstn  (rstn),
        .en_i  (xfer),
        .clr_i (state_q == ST_START),
        .dat_i (byte_dat_o),
        .sum_o (sum)
    );

endmodule
